// File: rtl/line_buffer_3x3_if.sv
// Pixel-stream-in / 3x3-window-out bundle for line_buffer_3x3.
// sof_out/eol_out exist only when WIN_FLAGS_EN is defined.
interface line_buffer_3x3_if;
    logic              valid_in;
    logic              sof_in;
    logic signed [7:0] pixel_in;
    logic signed [7:0] win0;
    logic signed [7:0] win1;
    logic signed [7:0] win2;
    logic signed [7:0] win3;
    logic signed [7:0] win4;
    logic signed [7:0] win5;
    logic signed [7:0] win6;
    logic signed [7:0] win7;
    logic signed [7:0] win8;
    logic              valid_out;
`ifdef WIN_FLAGS_EN
    logic              sof_out;
    logic              eol_out;

    modport master (
        output valid_in, sof_in, pixel_in,
        input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
        input  valid_out, sof_out, eol_out
    );
    modport slave (
        input  valid_in, sof_in, pixel_in,
        output win0, win1, win2, win3, win4, win5, win6, win7, win8,
        output valid_out, sof_out, eol_out
    );
`else
    modport master (
        output valid_in, sof_in, pixel_in,
        input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
        input  valid_out
    );
    modport slave (
        input  valid_in, sof_in, pixel_in,
        output win0, win1, win2, win3, win4, win5, win6, win7, win8,
        output valid_out
    );
`endif
endinterface

// File: rtl/line_buffer_3x3.sv
// Raster-scan 3x3 window generator: two line RAMs plus per-row shift taps.
// Define WIN_FLAGS_EN to add registered sof_out/eol_out window flags.
module line_buffer_3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    line_buffer_3x3_if.slave io_bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              r_valid;
    logic              w_accept;
    logic              w_sof;
    logic              w_win;
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic signed [7:0] w_tap_in [3];

    // lb0 holds the previous row, lb1 the row before it
    logic signed [7:0] r_lb0 [IMG_W];
    logic signed [7:0] r_lb1 [IMG_W];

    // A valid sof forces this pixel to (0,0) regardless of the counters
    always_comb begin
        w_accept    = io_bus.valid_in;
        w_sof       = io_bus.valid_in & io_bus.sof_in;
        w_col       = w_sof ? '0 : r_col;
        w_row       = w_sof ? '0 : r_row;
        w_win       = w_accept && (w_row >= ROW_MIN) && (w_col >= COL_MIN);
        w_tap_in[0] = r_lb1[w_col];
        w_tap_in[1] = r_lb0[w_col];
        w_tap_in[2] = io_bus.pixel_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Line RAMs carry no reset; rows 0/1 of every frame rewrite them before use
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_col] <= r_lb0[w_col];
            r_lb0[w_col] <= io_bus.pixel_in;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            logic signed [7:0] r_sh0;
            logic signed [7:0] r_sh1;
            logic signed [7:0] r_w0;
            logic signed [7:0] r_w1;
            logic signed [7:0] r_w2;

            // r_sh1/r_sh0 hold columns c-2/c-1 of this window row
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sh0 <= '0;
                    r_sh1 <= '0;
                    r_w0  <= '0;
                    r_w1  <= '0;
                    r_w2  <= '0;
                end else begin
                    if (w_accept) begin
                        r_sh1 <= r_sh0;
                        r_sh0 <= w_tap_in[gi];
                    end
                    if (w_win) begin
                        r_w0 <= r_sh1;
                        r_w1 <= r_sh0;
                        r_w2 <= w_tap_in[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_win;
        end
    end

`ifdef WIN_FLAGS_EN
    logic r_sof;
    logic r_eol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sof <= 1'b0;
            r_eol <= 1'b0;
        end else begin
            r_sof <= w_win && (w_row == ROW_MIN) && (w_col == COL_MIN);
            r_eol <= w_win && (w_col == COL_LAST);
        end
    end

    assign io_bus.sof_out = r_sof;
    assign io_bus.eol_out = r_eol;
`endif

    assign io_bus.valid_out = r_valid;
    assign io_bus.win0      = g_row[0].r_w0;
    assign io_bus.win1      = g_row[0].r_w1;
    assign io_bus.win2      = g_row[0].r_w2;
    assign io_bus.win3      = g_row[1].r_w0;
    assign io_bus.win4      = g_row[1].r_w1;
    assign io_bus.win5      = g_row[1].r_w2;
    assign io_bus.win6      = g_row[2].r_w0;
    assign io_bus.win7      = g_row[2].r_w1;
    assign io_bus.win8      = g_row[2].r_w2;
endmodule

// File: tb/tb_line_buffer_3x3.sv
// Self-checking bench for line_buffer_3x3 on a 5x5 image against a frame-array model.
module tb_line_buffer_3x3;
    localparam int W = 5;
    localparam int H = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_buffer_3x3_if bus ();

    line_buffer_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    // Model: the frame as a 2-D image plus the raster position of the next pixel
    int                m_row, m_col;
    logic signed [7:0] m_img [H][W];
    logic [71:0]       m_last;
    bit                exp_v, exp_sof, exp_eol;
    logic [71:0]       exp_w;

    function automatic void model_reset();
        m_row  = 0;
        m_col  = 0;
        m_last = '0;
    endfunction

    function automatic void model_step(input bit v, input bit s, input logic signed [7:0] p);
        exp_v   = 1'b0;
        exp_sof = 1'b0;
        exp_eol = 1'b0;
        if (v) begin
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            m_img[m_row][m_col] = p;
            if (m_row >= 2 && m_col >= 2) begin
                exp_v   = 1'b1;
                exp_sof = (m_row == 2 && m_col == 2);
                exp_eol = (m_col == W - 1);
                m_last  = {m_img[m_row-2][m_col-2], m_img[m_row-2][m_col-1], m_img[m_row-2][m_col],
                           m_img[m_row-1][m_col-2], m_img[m_row-1][m_col-1], m_img[m_row-1][m_col],
                           m_img[m_row][m_col-2],   m_img[m_row][m_col-1],   m_img[m_row][m_col]};
            end
            m_col = m_col + 1;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end
        end
        exp_w = m_last;
    endfunction

    function automatic logic [71:0] dut_taps();
        return {bus.win0, bus.win1, bus.win2, bus.win3, bus.win4,
                bus.win5, bus.win6, bus.win7, bus.win8};
    endfunction

    task automatic drive(input bit v, input bit s, input logic signed [7:0] p);
        bus.valid_in = v;
        bus.sof_in   = s;
        bus.pixel_in = p;
        model_step(v, s, p);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.sof_in   = 1'b0;
    endtask

    task automatic test_reset();
        bus.valid_in = 1'b0;
        bus.sof_in   = 1'b0;
        bus.pixel_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (bus.valid_out !== 1'b0) $display("FAIL reset_valid got=%0b want=0", bus.valid_out);
        else n_pass++;
        n_total++;
        if (dut_taps() !== 72'h0) $display("FAIL reset_taps got=%h want=0", dut_taps());
        else n_pass++;
        $display("reset: valid_out=%0b taps=%h", bus.valid_out, dut_taps());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        int nwin = 0;
        logic [71:0] first_w = '0, last_w = '0;
        logic [71:0] want_first, want_last;
        want_first = {8'sd0, 8'sd1, 8'sd2, 8'sd5, 8'sd6, 8'sd7, 8'sd10, 8'sd11, 8'sd12};
        want_last  = {8'sd12, 8'sd13, 8'sd14, 8'sd17, 8'sd18, 8'sd19, 8'sd22, 8'sd23, 8'sd24};
        for (int k = 0; k < W * H; k++) begin
            drive(1'b1, k == 0, 8'(k));
            n_total++;
            if (bus.valid_out !== exp_v) $display("FAIL stream_valid px=%0d got=%0b want=%0b", k, bus.valid_out, exp_v);
            else n_pass++;
            n_total++;
            if (dut_taps() !== exp_w) $display("FAIL stream_taps px=%0d got=%h want=%h", k, dut_taps(), exp_w);
            else n_pass++;
            if (bus.valid_out) begin
                if (nwin == 0) first_w = dut_taps();
                last_w = dut_taps();
                nwin++;
                $display("stream: window %0d after px %0d taps=%h", nwin, k, dut_taps());
            end
        end
        n_total++;
        if (nwin !== 9) $display("FAIL stream_count got=%0d want=9", nwin);
        else n_pass++;
        n_total++;
        if (first_w !== want_first) $display("FAIL stream_first got=%h want=%h", first_w, want_first);
        else n_pass++;
        n_total++;
        if (last_w !== want_last) $display("FAIL stream_last got=%h want=%h", last_w, want_last);
        else n_pass++;
    endtask

    task automatic test_gaps();
        int k = 0;
        int nwin = 0;
        int cyc = 0;
        while (k < W * H && cyc < 1000) begin
            bit v;
            v = ($urandom_range(0, 99) < 40);
            drive(v, v && (k == 0), 8'(k));
            if (v) k++;
            cyc++;
            n_total++;
            if (bus.valid_out !== exp_v) $display("FAIL gaps_valid cyc=%0d got=%0b want=%0b", cyc, bus.valid_out, exp_v);
            else n_pass++;
            n_total++;
            if (dut_taps() !== exp_w) $display("FAIL gaps_taps cyc=%0d got=%h want=%h", cyc, dut_taps(), exp_w);
            else n_pass++;
            if (bus.valid_out) nwin++;
        end
        $display("gaps: %0d pixels in %0d cycles, %0d windows", k, cyc, nwin);
        n_total++;
        if (nwin !== 9) $display("FAIL gaps_count got=%0d want=9", nwin);
        else n_pass++;
    endtask

    task automatic test_extremes();
        logic signed [7:0] pix;
        for (int k = 0; k < W * H; k++) begin
            int s_dut = 0;
            int s_exp = 0;
            logic [71:0] t;
            case (k)
                0:       pix = -8'sd128;
                1:       pix = 8'sd127;
                2:       pix = -8'sd1;
                W:       pix = 8'sd127;
                W + 1:   pix = -8'sd128;
                default: pix = 8'($urandom);
            endcase
            drive(1'b1, k == 0, pix);
            t = dut_taps();
            n_total++;
            if (t !== exp_w) $display("FAIL extreme_taps px=%0d got=%h want=%h", k, t, exp_w);
            else n_pass++;
            if (bus.valid_out) begin
                for (int j = 0; j < 9; j++) begin
                    s_dut += int'($signed(t[71-8*j -: 8]));
                    s_exp += int'($signed(exp_w[71-8*j -: 8]));
                end
                n_total++;
                if (s_dut != s_exp) $display("FAIL extreme_sum px=%0d got=%0d want=%0d", k, s_dut, s_exp);
                else n_pass++;
                $display("extremes: px %0d conv sum=%0d", k, s_dut);
            end
        end
    endtask

    task automatic test_sof_restart();
        int cuts [2] = '{7, 17};
        for (int ci = 0; ci < 2; ci++) begin
            int nwin = 0;
            for (int k = 0; k < cuts[ci]; k++) begin
                drive(1'b1, k == 0, 8'($urandom));
                n_total++;
                if (bus.valid_out !== exp_v || dut_taps() !== exp_w)
                    $display("FAIL sofA_win px=%0d got=%0b/%h want=%0b/%h", k, bus.valid_out, dut_taps(), exp_v, exp_w);
                else n_pass++;
            end
            for (int k = 0; k < W * H; k++) begin
                drive(1'b1, k == 0, 8'($urandom));
                n_total++;
                if (bus.valid_out !== exp_v || dut_taps() !== exp_w)
                    $display("FAIL sofB_win px=%0d got=%0b/%h want=%0b/%h", k, bus.valid_out, dut_taps(), exp_v, exp_w);
                else n_pass++;
                if (bus.valid_out) begin
                    nwin++;
                    n_total++;
                    if (k < 2 * W + 2) $display("FAIL sofB_early px=%0d got=window want=none", k);
                    else n_pass++;
                end
            end
            $display("sof_restart: cut at %0d, frame B windows=%0d", cuts[ci], nwin);
            n_total++;
            if (nwin !== 9) $display("FAIL sofB_count got=%0d want=9", nwin);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        int nwin = 0;
        logic [71:0] want_first;
        want_first = {8'sd0, 8'sd1, 8'sd2, 8'sd5, 8'sd6, 8'sd7, 8'sd10, 8'sd11, 8'sd12};
        for (int k = 0; k <= 3 * W + 2; k++) drive(1'b1, k == 0, 8'($urandom));
        n_total++;
        if (bus.valid_out !== 1'b1) $display("FAIL midrst_pre got=%0b want=1", bus.valid_out);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.valid_out !== 1'b0 || dut_taps() !== 72'h0)
            $display("FAIL midrst_async got=%0b/%h want=0/0", bus.valid_out, dut_taps());
        else n_pass++;
        $display("reset_midframe: outputs after async reset valid=%0b taps=%h", bus.valid_out, dut_taps());
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < W * H; k++) begin
            drive(1'b1, 1'b0, 8'(k));
            n_total++;
            if (bus.valid_out !== exp_v || dut_taps() !== exp_w)
                $display("FAIL midrst_win px=%0d got=%0b/%h want=%0b/%h", k, bus.valid_out, dut_taps(), exp_v, exp_w);
            else n_pass++;
            if (bus.valid_out) begin
                nwin++;
                if (nwin == 1) begin
                    n_total++;
                    if (dut_taps() !== want_first) $display("FAIL midrst_first got=%h want=%h", dut_taps(), want_first);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (nwin !== 9) $display("FAIL midrst_count got=%0d want=9", nwin);
        else n_pass++;
    endtask

`ifdef WIN_FLAGS_EN
    task automatic test_flags();
        int idx = 0;
        for (int k = 0; k < 2 * W * H; k++) begin
            drive(1'b1, k == 0, 8'($urandom));
            if (bus.valid_out) begin
                bit ws, we;
                idx++;
                ws = (idx == 1 || idx == 10);
                we = (idx % 3 == 0);
                n_total++;
                if (bus.sof_out !== ws || bus.eol_out !== we)
                    $display("FAIL flags_win idx=%0d got=%0b%0b want=%0b%0b", idx, bus.sof_out, bus.eol_out, ws, we);
                else n_pass++;
                $display("flags: window %0d sof_out=%0b eol_out=%0b", idx, bus.sof_out, bus.eol_out);
            end else begin
                n_total++;
                if (bus.sof_out !== 1'b0 || bus.eol_out !== 1'b0)
                    $display("FAIL flags_idle px=%0d got=%0b%0b want=00", k, bus.sof_out, bus.eol_out);
                else n_pass++;
            end
            n_total++;
            if (bus.sof_out !== exp_sof || bus.eol_out !== exp_eol || dut_taps() !== exp_w)
                $display("FAIL flags_model px=%0d got=%0b%0b/%h want=%0b%0b/%h", k, bus.sof_out, bus.eol_out,
                         dut_taps(), exp_sof, exp_eol, exp_w);
            else n_pass++;
        end
        n_total++;
        if (idx !== 18) $display("FAIL flags_count got=%0d want=18", idx);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_extremes();
        test_sof_restart();
        test_reset_midframe();
`ifdef WIN_FLAGS_EN
        test_flags();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
